mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Pipelined MEM stage with a load/store unit. It replaces the combinational pass-through MEM stage and folds the MEM/WB register into the block.
- Non-memory results, HI/LO writes and debug instruction pass to WB registered, with 1-cycle latency.
- Loads and stores run a request/acknowledge transaction on the data-memory bus. The pipeline stalls until the transaction ends.
- Features the previous stage lacks: byte/half/word access, misalignment detection, a bus-timeout watchdog and flush.

Parameters:
- ADDR_W, 32: width of mem_addr_o. Lower ADDR_W bits of alu_res_i are used.
- REG_AW, 5: register-file address width.
- TMO_W, 8: watchdog counter width. Timeout occurs at 2^TMO_W-1 cycles without ack.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX/MEM holds a live instruction
- flush_i  in  1  cancel current instruction
- inst_i  in  32  debug instruction
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- waddr_i  in  REG_AW  destination register
- reg_we_i  in  1  destination write enable
- alu_res_i  in  32  ALU result / effective address
- store_data_i  in  32  rt value for stores
- hi_we_i, lo_we_i  in  1 each
- hi_i, lo_i  in  32 each
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  transaction complete
- mem_rdata_i  in  32  read word, valid with ack
- stall_req_o  out  1  combinational; hold EX/MEM and upstream
- valid_o  out  1  WB entry valid
- waddr_o  out  REG_AW
- reg_we_o  out  1
- wdata_o  out  32
- hi_we_o, lo_we_o  out  1 each
- hi_o, lo_o  out  32 each
- inst_o  out  32
- misalign_o  out  1  one-cycle pulse
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE and the watchdog counter clears.
  - Every registered output becomes 0: valid_o, reg_we_o, hi_we_o, lo_we_o, mem_req_o, mem_we_o, misalign_o, bus_err_o, mem_addr_o, mem_be_o, mem_wdata_o, waddr_o, wdata_o, hi_o, lo_o, inst_o.
  - Reset mid-transaction drops mem_req_o next edge; the memory side must tolerate an abandoned request.
- live = valid_i & ~flush_i. Byte order is little-endian: lane k = bits [8k+7:8k], selected by addr[1:0].
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- IDLE, live and op NONE:
  - next edge: valid_o=1, WB outputs ← inputs, wdata_o=alu_res_i.
  - No stall.
- IDLE, live and misaligned memory op:
  - next edge: valid_o=1, misalign_o=1, reg_we_o=0, hi_we_o=0, lo_we_o=0.
  - No bus request, no stall.
- IDLE, live and aligned memory op:
  - stall_req_o=1 combinationally this cycle.
  - Latch op, byte offset, waddr, reg_we, hi/lo, inst.
  - Next edge: state=BUSY, mem_req_o=1, mem_we_o=(op≥6), mem_addr_o={addr[ADDR_W-1:2],2'b00}.
  - Byte enables: SB 0001<<off; SH 0011<<off; SW 1111. Loads also drive the same enables.
  - Store data: SB {4{b}}; SH {2{h}}; SW word.
  - WB outputs go to valid_o=0 at this edge.
- IDLE, not live: next edge valid_o=0, all write enables 0.
- BUSY:
  - Inputs are ignored; upstream holds them stable.
  - stall_req_o = ~mem_ack_i.
  - Request fields stay constant until ack.
  - Counter increments each cycle without ack.
- BUSY, mem_ack_i=1:
  - next edge: mem_req_o=0, state=IDLE, counter=0, valid_o=1.
  - Loads: wdata_o = lane data extracted at the offset. LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores: reg_we_o=0.
  - Stall drops in the ack cycle, so upstream presents the next instruction on the following cycle.
- BUSY, counter reaches 2^TMO_W-1 without ack:
  - next edge: mem_req_o=0, state=IDLE, bus_err_o=1, valid_o=1, reg_we_o=0.
  - stall_req_o=0 in that cycle.
- flush_i while BUSY:
  - Sets a sticky kill flag. The transaction still completes or times out.
  - The completing entry has reg_we_o=0, hi_we_o=0, lo_we_o=0, valid_o=0.
  - The flag clears on return to IDLE.
- misalign_o and bus_err_o are high for exactly one cycle.
- An ack arriving in IDLE is ignored.
- Minimum memory-op latency: accept at T, request visible at T+1; with ack at T+1, the WB entry is visible at T+2.

Test Plan:
- NOP/ALU pass-through: op NONE, alu_res=0x1234_5678, waddr=3, reg_we=1, hi_we=1, hi=0xA5 → next cycle wdata_o=0x12345678, waddr_o=3, hi_o=0xA5; stall_req_o=0 throughout.
- LB at addr 0x103, ack after 3 cycles, rdata=0x80FF_0000 → mem_be_o=1000, stall high 4 cycles, wdata_o=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH at 0x202, store_data=0x0000_BEEF → mem_addr_o=0x200, mem_be_o=1100, mem_wdata_o=0xBEEF_BEEF, mem_we_o=1; after ack reg_we_o=0.
- LW at 0x106 → misalign_o pulses 1 cycle, mem_req_o never rises, stall_req_o=0, reg_we_o=0.
- TMO_W=3, LW at 0x40, no ack → mem_req_o high 7 cycles, then bus_err_o=1 for one cycle, state returns to IDLE, next op accepted normally.
- LW in BUSY with flush_i pulsed and ack 2 cycles later → valid_o=0, reg_we_o=0. Separately, assert rst mid-BUSY → next edge mem_req_o=0 and all outputs 0.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU and the memory system.
// The request side holds its fields stable until ack.
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage with load/store unit and folded MEM/WB register.
// Memory ops stall upstream until ack or watchdog timeout.
module mem_stage_lsu #(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [31:0]       inst_i,
    input  logic [3:0]        mem_op_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic              reg_we_i,
    input  logic [31:0]       alu_res_i,
    input  logic [31:0]       store_data_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    mem_stage_lsu_if.master   bus,
    output logic              stall_req_o,
    output logic              valid_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic              reg_we_o,
    output logic [31:0]       wdata_o,
    output logic              hi_we_o,
    output logic              lo_we_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic [31:0]       inst_o,
    output logic              misalign_o,
    output logic              bus_err_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Last count before timeout; the expiring cycle is the (2^TMO_W-1)th.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    state_t            state_n;
    logic [TMO_W-1:0]  cnt_q;
    logic              kill_q;

    logic [3:0]        op_q;
    logic [1:0]        off_q;
    logic [REG_AW-1:0] waddr_q;
    logic              reg_we_q;
    logic              hi_we_q;
    logic              lo_we_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       inst_q;

    logic        live;
    logic [1:0]  off;
    logic        is_mem;
    logic        is_store;
    logic        op_b;
    logic        op_h;
    logic        misal;
    logic        accept;
    logic [3:0]  be_n;
    logic [31:0] wd_n;

    logic        done;
    logic        tmo;
    logic        kill_now;
    logic        is_load_q;
    logic [31:0] lane;
    logic [31:0] ld_data;

    always_comb begin
        live     = valid_i & ~flush_i;
        off      = alu_res_i[1:0];
        is_mem   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
        is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        op_b     = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU)
                || (mem_op_i == OP_SB);
        op_h     = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU)
                || (mem_op_i == OP_SH);
        misal    = 1'b0;
        be_n     = 4'b1111;
        wd_n     = store_data_i;
        unique case (1'b1)
            op_b: begin
                be_n = 4'b0001 << off;
                wd_n = {4{store_data_i[7:0]}};
            end
            op_h: begin
                misal = off[0];
                be_n  = 4'b0011 << off;
                wd_n  = {2{store_data_i[15:0]}};
            end
            default: misal = is_mem & (off != 2'b00);
        endcase
        accept = (state == IDLE) & live & is_mem & ~misal;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = BUSY;
            BUSY:    if (done || tmo) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        done        = (state == BUSY) & bus.ack;
        tmo         = (state == BUSY) & ~bus.ack & (cnt_q == TMO_LAST);
        kill_now    = kill_q | flush_i;
        stall_req_o = accept | ((state == BUSY) & ~bus.ack & ~tmo);
        is_load_q   = (op_q >= OP_LB) && (op_q <= OP_LW);
        lane        = bus.rdata >> {off_q, 3'b000};
        unique case (op_q)
            OP_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  ld_data = {24'h0, lane[7:0]};
            OP_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  ld_data = {16'h0, lane[15:0]};
            default: ld_data = bus.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state != BUSY || done || tmo) cnt_q <= '0;
        else                                     cnt_q <= cnt_q + 1'b1;
    end

    // A flush during BUSY cannot cancel the bus cycle, only its write-back.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY || done || tmo) kill_q <= 1'b0;
        else if (flush_i)                        kill_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            reg_we_o   <= 1'b0;
            hi_we_o    <= 1'b0;
            lo_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            hi_o       <= '0;
            lo_o       <= '0;
            inst_o     <= '0;
            bus.req    <= 1'b0;
            bus.we     <= 1'b0;
            bus.addr   <= '0;
            bus.be     <= '0;
            bus.wdata  <= '0;
            op_q       <= '0;
            off_q      <= '0;
            waddr_q    <= '0;
            reg_we_q   <= 1'b0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            inst_q     <= '0;
        end else begin
            valid_o    <= 1'b0;
            reg_we_o   <= 1'b0;
            hi_we_o    <= 1'b0;
            lo_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (state == IDLE) begin
                if (live && !is_mem) begin
                    valid_o  <= 1'b1;
                    reg_we_o <= reg_we_i;
                    hi_we_o  <= hi_we_i;
                    lo_we_o  <= lo_we_i;
                    waddr_o  <= waddr_i;
                    wdata_o  <= alu_res_i;
                    hi_o     <= hi_i;
                    lo_o     <= lo_i;
                    inst_o   <= inst_i;
                end else if (live && misal) begin
                    valid_o    <= 1'b1;
                    misalign_o <= 1'b1;
                    waddr_o    <= waddr_i;
                    wdata_o    <= alu_res_i;
                    hi_o       <= hi_i;
                    lo_o       <= lo_i;
                    inst_o     <= inst_i;
                end else if (accept) begin
                    bus.req   <= 1'b1;
                    bus.we    <= is_store;
                    bus.addr  <= {alu_res_i[ADDR_W-1:2], 2'b00};
                    bus.be    <= be_n;
                    bus.wdata <= wd_n;
                    op_q      <= mem_op_i;
                    off_q     <= off;
                    waddr_q   <= waddr_i;
                    reg_we_q  <= reg_we_i;
                    hi_we_q   <= hi_we_i;
                    lo_we_q   <= lo_we_i;
                    hi_q      <= hi_i;
                    lo_q      <= lo_i;
                    inst_q    <= inst_i;
                end
            end else if (done || tmo) begin
                bus.req   <= 1'b0;
                valid_o   <= ~kill_now;
                reg_we_o  <= done & is_load_q & reg_we_q & ~kill_now;
                hi_we_o   <= hi_we_q & ~kill_now;
                lo_we_o   <= lo_we_q & ~kill_now;
                waddr_o   <= waddr_q;
                wdata_o   <= (done && is_load_q) ? ld_data : '0;
                hi_o      <= hi_q;
                lo_o      <= lo_q;
                inst_o    <= inst_q;
                bus_err_o <= tmo;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table plus
// timeout, flush, reset and idle-ack sequences.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i;
    logic        flush_i;
    logic [31:0] inst_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  waddr_i;
    logic        reg_we_i;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        stall_req_o;
    logic        valid_o;
    logic [4:0]  waddr_o;
    logic        reg_we_o;
    logic [31:0] wdata_o;
    logic        hi_we_o;
    logic        lo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] inst_o;
    logic        misalign_o;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.ADDR_W(32)) bus ();

    mem_stage_lsu #(.ADDR_W(32), .REG_AW(5), .TMO_W(3)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .inst_i(inst_i), .mem_op_i(mem_op_i), .waddr_i(waddr_i),
        .reg_we_i(reg_we_i), .alu_res_i(alu_res_i),
        .store_data_i(store_data_i), .hi_we_i(hi_we_i),
        .lo_we_i(lo_we_i), .hi_i(hi_i), .lo_i(lo_i), .bus(bus),
        .stall_req_o(stall_req_o), .valid_o(valid_o),
        .waddr_o(waddr_o), .reg_we_o(reg_we_o), .wdata_o(wdata_o),
        .hi_we_o(hi_we_o), .lo_we_o(lo_we_o), .hi_o(hi_o),
        .lo_o(lo_o), .inst_o(inst_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic        vld;
        logic        fl;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic        hwe;
        int          dly;
        logic [31:0] rd;
        logic        mem;
        logic        bwe;
        logic [31:0] badr;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic        ev;
        logic        erwe;
        logic        ehwe;
        logic        cwd;
        logic [31:0] ewd;
        logic        emis;
        int          est;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic vld, input logic fl,
                       input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic hwe,
                       input logic [4:0] wa, input logic [31:0] inst);
        valid_i      = vld;
        flush_i      = fl;
        mem_op_i     = op;
        alu_res_i    = addr;
        store_data_i = sd;
        hi_we_i      = hwe;
        waddr_i      = wa;
        inst_i       = inst;
        reg_we_i     = 1'b1;
        lo_we_i      = 1'b0;
        hi_i         = 32'h0000_00A5;
        lo_i         = 32'h0000_005A;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [4:0]  wa;
        logic [31:0] inst;
        string       nm;
        int          st;
        wa   = 5'(idx + 1);
        inst = 32'hC0DE_0000 + 32'(idx);
        nm   = $sformatf("v%0d", idx);
        st   = 0;
        put(v.vld, v.fl, v.op, v.addr, v.sd, v.hwe, wa, inst);
        @(negedge clk);
        st += int'(stall_req_o);
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        if (v.mem) begin
            for (int i = 0; i <= v.dly; i++) begin
                bus.ack   = (i == v.dly);
                bus.rdata = (i == v.dly) ? v.rd : 32'h5555_AAAA;
                @(negedge clk);
                if (i == 0) begin
                    chk({nm, "_req"}, 32'(bus.req), 32'd1);
                    chk({nm, "_bus_we"}, 32'(bus.we), 32'(v.bwe));
                    chk({nm, "_addr"}, bus.addr, v.badr);
                    chk({nm, "_be"}, 32'(bus.be), 32'(v.be));
                    chk({nm, "_bus_wdata"}, bus.wdata, v.bwd);
                end
                st += int'(stall_req_o);
                @(posedge clk); #1;
                bus.ack = 1'b0;
            end
        end
        @(negedge clk);
        chk({nm, "_stall_cycles"}, 32'(st), 32'(v.est));
        chk({nm, "_valid"}, 32'(valid_o), 32'(v.ev));
        chk({nm, "_reg_we"}, 32'(reg_we_o), 32'(v.erwe));
        chk({nm, "_hi_we"}, 32'(hi_we_o), 32'(v.ehwe));
        chk({nm, "_misalign"}, 32'(misalign_o), 32'(v.emis));
        chk({nm, "_req_idle"}, 32'(bus.req), 32'd0);
        if (v.ev && !v.emis) begin
            chk({nm, "_waddr"}, 32'(waddr_o), 32'(wa));
            chk({nm, "_inst"}, inst_o, inst);
        end
        if (v.cwd) chk({nm, "_wdata"}, wdata_o, v.ewd);
        if (v.ehwe) chk({nm, "_hi"}, hi_o, 32'h0000_00A5);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_mis_pulse"}, 32'(misalign_o), 32'd0);
        chk({nm, "_valid_drop"}, 32'(valid_o), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int reqc;
        int stc;
        logic seen;
        put(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.ack   = 1'b0;
        bus.rdata = '0;

        vecs[0]  = '{1'b1, 1'b0, 4'd0, 32'h1234_5678, 32'h0, 1'b1, 0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                     1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 4'd1, 32'h0000_0103, 32'h0, 1'b0, 3, 32'h80FF_0000,
                     1'b1, 1'b0, 32'h100, 4'b1000, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0, 4};
        vecs[2]  = '{1'b1, 1'b0, 4'd2, 32'h0000_0103, 32'h0, 1'b0, 3, 32'h80FF_0000,
                     1'b1, 1'b0, 32'h100, 4'b1000, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 4};
        vecs[3]  = '{1'b1, 1'b0, 4'd7, 32'h0000_0202, 32'h0000_BEEF, 1'b0, 1, 32'h0,
                     1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2};
        vecs[4]  = '{1'b1, 1'b0, 4'd5, 32'h0000_0106, 32'h0, 1'b0, 0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0};
        vecs[5]  = '{1'b1, 1'b0, 4'd3, 32'h0000_0102, 32'h0, 1'b0, 0, 32'h8001_1234,
                     1'b1, 1'b0, 32'h100, 4'b1100, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0, 1};
        vecs[6]  = '{1'b1, 1'b0, 4'd4, 32'h0000_0102, 32'h0, 1'b0, 0, 32'h8001_1234,
                     1'b1, 1'b0, 32'h100, 4'b1100, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_8001, 1'b0, 1};
        vecs[7]  = '{1'b1, 1'b0, 4'd6, 32'h0000_0301, 32'h1234_56AB, 1'b0, 2, 32'h0,
                     1'b1, 1'b1, 32'h300, 4'b0010, 32'hABAB_ABAB,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3};
        vecs[8]  = '{1'b1, 1'b0, 4'd8, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0, 0, 32'h0,
                     1'b1, 1'b1, 32'h400, 4'b1111, 32'hDEAD_BEEF,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1};
        vecs[9]  = '{1'b1, 1'b0, 4'd5, 32'h0000_0044, 32'h0, 1'b0, 2, 32'hCAFE_F00D,
                     1'b1, 1'b0, 32'h44, 4'b1111, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 3};
        vecs[10] = '{1'b0, 1'b0, 4'd5, 32'h0000_0044, 32'h0, 1'b0, 0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b1, 4'd5, 32'h0000_0044, 32'h0, 1'b0, 0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0};
        vecs[12] = '{1'b1, 1'b0, 4'd12, 32'hA5A5_0001, 32'h0, 1'b0, 0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 0};
        vecs[13] = '{1'b1, 1'b0, 4'd7, 32'h0000_0201, 32'h0000_1111, 1'b0, 0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0};
        vecs[14] = '{1'b1, 1'b0, 4'd1, 32'h0000_0100, 32'h0, 1'b0, 1, 32'h0000_007F,
                     1'b1, 1'b0, 32'h100, 4'b0001, 32'h0,
                     1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_007F, 1'b0, 2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_reg_we", 32'(reg_we_o), 32'd0);
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_be", 32'(bus.be), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Watchdog: LW with no ack
        put(1'b1, 1'b0, 4'd5, 32'h40, 32'h0, 1'b0, 5'd7, 32'hAAAA_0001);
        @(negedge clk);
        stc = int'(stall_req_o);
        @(posedge clk); #1;
        valid_i = 1'b0;
        reqc = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.req) begin
                seen = 1'b1;
                break;
            end
            reqc++;
            stc += int'(stall_req_o);
            @(posedge clk); #1;
        end
        chk("tmo_bounded", 32'(seen), 32'd1);
        chk("tmo_req_cycles", 32'(reqc), 32'd7);
        chk("tmo_stall_cycles", 32'(stc), 32'd7);
        chk("tmo_bus_err", 32'(bus_err_o), 32'd1);
        chk("tmo_valid", 32'(valid_o), 32'd1);
        chk("tmo_reg_we", 32'(reg_we_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo_err_pulse", 32'(bus_err_o), 32'd0);
        @(posedge clk); #1;
        run_vec(vecs[9], 20);

        // Flush while BUSY, ack two cycles later
        put(1'b1, 1'b0, 4'd5, 32'h80, 32'h0, 1'b0, 5'd9, 32'hAAAA_0002);
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(posedge clk); #1;
        bus.ack   = 1'b1;
        bus.rdata = 32'h1111_1111;
        @(negedge clk);
        chk("fl_ack_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        chk("fl_valid", 32'(valid_o), 32'd0);
        chk("fl_reg_we", 32'(reg_we_o), 32'd0);
        chk("fl_req", 32'(bus.req), 32'd0);
        @(posedge clk); #1;
        run_vec(vecs[0], 21);

        // Reset in the middle of a transaction
        put(1'b1, 1'b0, 4'd8, 32'h84, 32'h1357_9BDF, 1'b0, 5'd11, 32'hAAAA_0003);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("rb_req_up", 32'(bus.req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rb_req", 32'(bus.req), 32'd0);
        chk("rb_bus_we", 32'(bus.we), 32'd0);
        chk("rb_addr", bus.addr, 32'd0);
        chk("rb_be", 32'(bus.be), 32'd0);
        chk("rb_bus_wdata", bus.wdata, 32'd0);
        chk("rb_valid", 32'(valid_o), 32'd0);
        chk("rb_waddr", 32'(waddr_o), 32'd0);
        chk("rb_wdata", wdata_o, 32'd0);
        chk("rb_inst", inst_o, 32'd0);
        chk("rb_hi", hi_o, 32'd0);
        chk("rb_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_req_stays", 32'(bus.req), 32'd0);
        @(posedge clk); #1;

        // Stray ack while IDLE
        bus.ack   = 1'b1;
        bus.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_valid", 32'(valid_o), 32'd0);
        chk("idle_ack_req", 32'(bus.req), 32'd0);
        @(posedge clk); #1;
        run_vec(vecs[14], 22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
